// File: rtl/seg7_scan_ctrl.sv
// seg7_scan_ctrl
// Multiplexed 8-digit seven-segment scan controller running on led_clk.
// The asynchronous CPU word is double-sampled. It is copied into a shadow
// register only at a frame boundary, and only when two consecutive samples
// agree, so a frame never shows a torn value. Each digit slot starts with a
// blank dead time (anti-ghosting). That is followed by a brightness-controlled
// on-window. Leading zeros can be suppressed, and a per-digit decimal-point
// mask is supported. AN and SEG are both registered and always move together.

module seg7_scan_ctrl #(
    parameter int SLOT_TICKS = 16,
    parameter int DEAD_TICKS = 1
) (
    input  logic        led_clk,
    input  logic        rst,
    input  logic [31:0] data_in,
    input  logic [7:0]  dp_in,
    input  logic        blank_lz,
    input  logic [3:0]  brightness,
    output logic [7:0]  AN,
    output logic [7:0]  SEG,
    output logic        frame_tick
);

    // Slot counter width: SLOT_TICKS is at most 256, so c never needs more than 8 bits.
    localparam int CW = (SLOT_TICKS > 2) ? $clog2(SLOT_TICKS) : 1;
    localparam logic [CW-1:0] C_LAST = CW'(SLOT_TICKS - 1);
    // Window arithmetic is done at 10 bits: DEAD_TICKS + 15 can exceed 255.
    localparam logic [9:0] DEAD_W = 10'(DEAD_TICKS);

    // Active-low {g,f,e,d,c,b,a} pattern for one hex nibble.
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] seg;
        case (nib)
            4'h0:    seg = 7'h40;
            4'h1:    seg = 7'h79;
            4'h2:    seg = 7'h24;
            4'h3:    seg = 7'h30;
            4'h4:    seg = 7'h19;
            4'h5:    seg = 7'h12;
            4'h6:    seg = 7'h02;
            4'h7:    seg = 7'h78;
            4'h8:    seg = 7'h00;
            4'h9:    seg = 7'h10;
            4'hA:    seg = 7'h08;
            4'hB:    seg = 7'h03;
            4'hC:    seg = 7'h46;
            4'hD:    seg = 7'h21;
            4'hE:    seg = 7'h06;
            4'hF:    seg = 7'h0E;
            default: seg = 7'h7F;
        endcase
        return seg;
    endfunction

    // True when every nibble from position 'first' up to 7 is zero.
    function automatic logic nibbles_zero_from(input logic [31:0] data, input logic [2:0] first);
        logic zero;
        zero = 1'b1;
        for (int i = 0; i < 8; i++) begin
            if ((i >= int'(first)) && (data[4*i +: 4] != 4'h0)) begin
                zero = 1'b0;
            end else begin
                zero = zero;
            end
        end
        return zero;
    endfunction

    // Scan state
    logic [CW-1:0] c_r;
    logic [2:0]    d_r;

    // Input sampler and per-frame shadow
    logic [31:0] samp_data_r;
    logic [7:0]  samp_dp_r;
    logic [31:0] shadow_data_r;
    logic [7:0]  shadow_dp_r;

    // Registered outputs
    logic [7:0] an_r;
    logic [7:0] seg_r;
    logic       frame_tick_r;

    // Combinational helpers
    logic       boundary_s;
    logic       stable_s;
    logic [9:0] c_ext_s;
    logic       window_s;
    logic [3:0] cur_nib_s;
    logic       cur_dp_s;
    logic       lz_s;
    logic       lit_s;
    logic [7:0] an_next_s;
    logic [7:0] seg_next_s;

    // Last cycle of the frame: last digit, last tick of its slot.
    assign boundary_s = (d_r == 3'd7) && (c_r == C_LAST);

    // Input is stable when it matches last cycle's sample, so one clean edge
    // separates any change from the shadow load.
    assign stable_s = (data_in == samp_data_r) && (dp_in == samp_dp_r);

    // c is always below SLOT_TICKS, so the upper bound only needs DEAD+brightness.
    assign c_ext_s  = {{(10 - CW){1'b0}}, c_r};
    assign window_s = (c_ext_s >= DEAD_W) && (c_ext_s < (DEAD_W + {6'd0, brightness}));

    assign cur_nib_s = shadow_data_r[{d_r, 2'b00} +: 4];
    assign cur_dp_s  = shadow_dp_r[d_r];

    // Digit 0 always shows, so a zero word still reads "0".
    assign lz_s = blank_lz && (d_r != 3'd0) && nibbles_zero_from(shadow_data_r, d_r);

    // A blanked digit still lights its anode when it has to show its decimal point.
    assign lit_s = window_s && (!lz_s || cur_dp_s);

    // Next anode/cathode pattern; cathodes stay dark whenever the anode is off.
    always_comb begin
        an_next_s  = 8'hFF;
        seg_next_s = 8'hFF;
        if (lit_s) begin
            an_next_s = ~(8'h01 << d_r);
            if (lz_s) begin
                seg_next_s = {~cur_dp_s, 7'h7F};
            end else begin
                seg_next_s = {~cur_dp_s, hex_to_seg(cur_nib_s)};
            end
        end else begin
            an_next_s  = 8'hFF;
            seg_next_s = 8'hFF;
        end
    end

    // Slot tick and digit counters; digit advances when the slot wraps.
    always_ff @(posedge led_clk) begin
        if (rst) begin
            c_r <= '0;
            d_r <= 3'd0;
        end else if (c_r == C_LAST) begin
            c_r <= '0;
            d_r <= d_r + 3'd1;
        end else begin
            c_r <= c_r + CW'(1);
            d_r <= d_r;
        end
    end

    // Every-cycle sample of the asynchronous CPU word and DP mask.
    always_ff @(posedge led_clk) begin
        if (rst) begin
            samp_data_r <= 32'h0000_0000;
            samp_dp_r   <= 8'h00;
        end else begin
            samp_data_r <= data_in;
            samp_dp_r   <= dp_in;
        end
    end

    // Shadow only changes at a frame boundary with stable input; otherwise retry next frame.
    always_ff @(posedge led_clk) begin
        if (rst) begin
            shadow_data_r <= 32'h0000_0000;
            shadow_dp_r   <= 8'h00;
        end else if (boundary_s && stable_s) begin
            shadow_data_r <= samp_data_r;
            shadow_dp_r   <= samp_dp_r;
        end else begin
            shadow_data_r <= shadow_data_r;
            shadow_dp_r   <= shadow_dp_r;
        end
    end

    // Output register: AN, SEG and frame_tick reflect the previous cycle's scan state.
    always_ff @(posedge led_clk) begin
        if (rst) begin
            an_r         <= 8'hFF;
            seg_r        <= 8'hFF;
            frame_tick_r <= 1'b0;
        end else begin
            an_r         <= an_next_s;
            seg_r        <= seg_next_s;
            frame_tick_r <= boundary_s;
        end
    end

    assign AN         = an_r;
    assign SEG        = seg_r;
    assign frame_tick = frame_tick_r;

endmodule
